// File: rtl/y_demux_queue.sv
// Registered 1-to-2 demultiplexer: routes in_data to queue A (in_sel=0) or queue B (in_sel=1).
// Latency: a word accepted at edge N appears on a_*/b_* in cycle N+1; no combinational in-to-out path.
// Backpressure: in_ready drops when the selected queue is full; a pop in the same cycle does not free space.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset (clears all state)
//   in_valid/in_ready      producer handshake; in_data is the word, in_sel picks A (0) or B (1)
//   a_valid/a_ready/a_data queue A head and consumer handshake
//   b_valid/b_ready/b_data queue B head and consumer handshake
//   stat_a, stat_b         16-bit saturating push counters, present only with Y_DEMUX_STATS_EN

// Generic DEPTH-entry queue used for each output side.
// Latency: a pushed word is readable the cycle after the push edge.
// Backpressure: push is ignored when full, even if a pop occurs in the same cycle.
module y_demux_fifo #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic            valid,
  output logic            full,
  output logic [SIZE-1:0] data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];
  // Fullness is judged on the current count only, so there is no fall-through.
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Storage is cleared too so the data outputs never show X.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Top level: steers one word stream into two independent queues.
// Latency: one cycle from input handshake to output visibility.
// Backpressure: in_ready depends only on in_sel and the selected queue's fullness.
// Optional statistics outputs are enabled by the Y_DEMUX_STATS_EN macro.
module y_demux_queue #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_sel,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [SIZE-1:0] a_data,
  output logic            b_valid,
  input  logic            b_ready,
  output logic [SIZE-1:0] b_data
`ifdef Y_DEMUX_STATS_EN
  ,
  output logic [15:0]     stat_a,
  output logic [15:0]     stat_b
`endif
);
  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // Never a function of in_valid, so the producer may wait on in_ready.
  assign in_ready = in_sel ? ~full_b : ~full_a;
  assign push_a   = in_valid & in_ready & ~in_sel;
  assign push_b   = in_valid & in_ready &  in_sel;

  y_demux_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_data),
    .pop       (a_ready),
    .valid     (a_valid),
    .full      (full_a),
    .data      (a_data)
  );

  y_demux_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_data),
    .pop       (b_ready),
    .valid     (b_valid),
    .full      (full_b),
    .data      (b_data)
  );

`ifdef Y_DEMUX_STATS_EN
  // Push counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_a <= '0;
      stat_b <= '0;
    end else begin
      if (push_a && stat_a != 16'hFFFF) stat_a <= stat_a + 16'd1;
      if (push_b && stat_b != 16'hFFFF) stat_b <= stat_b + 16'd1;
    end
  end
`endif
endmodule
